// File: rtl/dmem_lsu_pkg.sv
// Shared size/state encodings and store-lane helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Reserved size 2'b11 counts as misaligned so the trap build rejects it.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline request/response and RAM port-B signals of the load/store unit.
interface dmem_lsu_if #(
  parameter int AW = 11
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addrb;
  logic [31:0]   ram_dinb;
  logic          ram_web;
  logic [3:0]    ram_wemb;
  logic          ram_enb;
  logic [31:0]   ram_doutb;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_doutb,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_addrb, ram_dinb, ram_web, ram_wemb, ram_enb
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, ram_doutb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_addrb, ram_dinb, ram_web, ram_wemb, ram_enb
  );
endinterface

// File: rtl/dmem_load_fmt.sv
// Load formatter: lane select plus sign/zero extension of a RAM read word.
// Purely combinational; no handshake, no backpressure.
module dmem_load_fmt
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: data = {{16{lane_h[15] & ~uns}}, lane_h};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for RAM port B; store response at T+2, load at T+3, no response backpressure.
// `define MISALIGN_TRAP_EN rejects misaligned/reserved-size requests with rsp_err at T+1 instead of force-aligning.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int RAM_DEPTH = 2048,
  parameter int RAM_AW    = 11
) (
  input logic       clk,
  input logic       rst,
  dmem_lsu_if.slave bus
);
  localparam logic [RAM_AW-1:0] WORD_MASK = RAM_AW'(RAM_DEPTH - 1);

  lsu_state_e        state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [RAM_AW-1:0] addrb_q, addrb_d;
  logic [31:0]       dinb_q, dinb_d;
  logic              web_q, web_d;
  logic [3:0]        wemb_q, wemb_d;
  logic              enb_q, enb_d;
  logic [31:0]       load_data;
  logic              unused_addr_hi;

  // Upper address bits are ignored so accesses wrap modulo the RAM size.
  assign unused_addr_hi = ^bus.req_addr[31:RAM_AW+2];

  dmem_load_fmt u_fmt (
    .word (bus.ram_doutb),
    .addr (addr_q),
    .size (size_q),
    .uns  (uns_q),
    .data (load_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    we_d        = we_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    addrb_d     = addrb_q;
    dinb_d      = dinb_q;
    web_d       = 1'b0;
    wemb_d      = 4'b0000;
    enb_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && ready_q) begin
          addr_d = bus.req_addr[1:0];
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          we_d   = bus.req_we;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
`else
          begin
`endif
            state_d = ST_ACCESS;
            addrb_d = bus.req_addr[RAM_AW+1:2] & WORD_MASK;
            dinb_d  = lane_replicate(bus.req_size, bus.req_wdata);
            web_d   = bus.req_we;
            wemb_d  = bus.req_we ? byte_strobe(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
            enb_d   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      addrb_q     <= '0;
      dinb_q      <= 32'h0;
      web_q       <= 1'b0;
      wemb_q      <= 4'b0000;
      enb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addrb_q     <= addrb_d;
      dinb_q      <= dinb_d;
      web_q       <= web_d;
      wemb_q      <= wemb_d;
      enb_q       <= enb_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ram_addrb = addrb_q;
  assign bus.ram_dinb  = dinb_q;
  assign bus.ram_web   = web_q;
  assign bus.ram_wemb  = wemb_q;
  assign bus.ram_enb   = enb_q;
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the RISC-V core's memory stage and port B (read/write) of the dual-port instruction/data RAM.
- Accepts one byte, halfword or word access at a time.
- For stores: replicates write data across byte lanes and generates the 4-bit byte write strobe.
- For loads: sequences the RAM's registered 2-cycle read, then extracts and sign/zero-extends the addressed lane.
- Returns a single-cycle response pulse to the pipeline.

Parameters:
RAM_DEPTH, 2048, RAM depth in 32-bit words.
RAM_AW, 11, word-address width = clog2(RAM_DEPTH); must match the RAM's port-B address width.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  access request.
req_ready  out  1  high only in IDLE with rst low; handshake = req_valid & req_ready.
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
req_wdata  in  32  store data, right-justified.
rsp_valid  out  1  one-cycle completion pulse.
rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores.
rsp_err  out  1  misalignment error, valid with rsp_valid; tied 0 without the optional feature.
ram_addrb  out  RAM_AW  word address = req_addr[RAM_AW+1:2].
ram_dinb  out  32  lane-replicated write data.
ram_web  out  1  write enable.
ram_wemb  out  4  byte strobes.
ram_enb  out  1  port enable.
ram_doutb  in  32  RAM read data; valid one cycle after address is sampled.

Behaviour:
- All outputs are registered.
- Reset values:
  - req_ready = 0 while rst is high; 1 in the first cycle after rst deasserts.
  - All other outputs = 0.
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - On handshake, register address/size/unsigned into addr_q/size_q/uns_q.
  - Drive ram_addrb, ram_enb = 1, ram_dinb, ram_web = req_we and ram_wemb.
  - Go to ACCESS.
- ACCESS (RAM samples port B at the end of this cycle):
  - Next state: IDLE for a store, RDATA for a load.
  - Drive ram_web = 0, ram_wemb = 0, ram_enb = 0 for the next cycle.
  - Store: pulse rsp_valid next cycle with rsp_rdata = 0.
- RDATA:
  - Sample ram_doutb, format it, register into rsp_rdata, pulse rsp_valid, go to IDLE.
- Latency measured from the handshake edge T:
  - Store: rsp_valid high in cycle T+2.
  - Load: rsp_valid high in cycle T+3.
  - Throughput: one store per 2 cycles, one load per 3 cycles.
- The response has no backpressure; the consumer must accept it.
- Store lanes:
  - byte: dinb = {4{wdata[7:0]}}, wemb = 4'b0001 << addr[1:0].
  - half: dinb = {2{wdata[15:0]}}, wemb = addr[1] ? 1100 : 0011.
  - word: dinb = wdata, wemb = 1111.
- Load extract:
  - byte: lane selected by addr_q[1:0].
  - half: lane selected by addr_q[1].
  - word: full word.
  - Extend to 32 bits per uns_q.
- Address bits above RAM_AW+1 are ignored, so accesses wrap modulo RAM size.
- Misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0), feature off:
  - Low bits are forced to alignment and the access proceeds.
- Reset mid-operation:
  - If rst is high in ACCESS, the already-driven store still commits at that edge.
  - All state returns to IDLE and no rsp_valid is produced.
- req_valid while not ready: ignored; request must be held by the upstream stage.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned request is accepted but not issued: ram_enb, ram_web and ram_wemb stay 0.
  - rsp_valid pulses at T+1 with rsp_err = 1 and rsp_rdata = 0; FSM stays in IDLE.
  - Reserved size 11 is also flagged as an error.
- Undefined:
  - Force-align behaviour as described above; rsp_err constant 0.

Decomposition:
- Shared defines/package:
  - Size encodings: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - FSM state encodings.
  - Byte-strobe generation function.
- One sub-module, dmem_load_fmt: combinational lane select plus sign/zero-extend.
  - Inputs: 32-bit word, addr[1:0], size, unsigned flag.

Test Plan:
- Word store 0x11223344 to addr 0x40, then word load 0x40 → wemb = 1111 at T+1, rsp_valid at T+2 (store); load rsp_valid at T+3 with rdata = 0x11223344.
- Byte store 0xAB to 0x43 over word 0x11223344, then word load → wemb = 1000, dinb = 0xABABABAB; load returns 0xAB223344.
- Byte load 0x43 signed → 0xFFFFFFAB; unsigned → 0x000000AB. Half load 0x42 signed on 0x8001_xxxx → 0xFFFF8001.
- Half store 0xBEEF to 0x41:
  - MISALIGN_TRAP_EN off: wemb = 0011, memory low half = 0xBEEF.
  - MISALIGN_TRAP_EN on: rsp_valid at T+1 with rsp_err = 1, no RAM write.
- rst asserted during RDATA of a load → no rsp_valid; req_ready = 0 during reset and 1 the cycle after release; all RAM controls 0.
- Back-to-back requests with req_valid held high → second handshake no earlier than T+2 (store) or T+3 (load); address 0x2000 with RAM_DEPTH = 2048 wraps to word 0.
